// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Counter encoding: bit 1 is the predicted direction.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/bp_ctr_next.sv
// Saturating 2-bit counter next state: taken counts up to strong taken,
// not-taken counts down to strong not-taken.
module bp_ctr_next
    import bp_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/bp_pht_sched.sv
// Gshare PHT owner: arbitrates fetch lookups against queued resolve updates
// so the table sees at most one access per cycle; maintains and repairs the GHR.
module bp_pht_sched
    import bp_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_pc,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [IDX_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic             upd_ready,
    output logic [IDX_W-1:0] ghr
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    ctr_t             r_pht [ENTRIES];
    logic [IDX_W-1:0] r_q_idx [QDEPTH];
    logic             r_q_tk  [QDEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_ghr;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;
    logic [IDX_W-1:0] r_pred_ghr;

    logic             w_full;
    logic             w_empty;
    logic             w_repair;
    logic             w_lookup;
    logic             w_enq;
    logic             w_drain;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_tk;
    ctr_t             w_ctr_new;
    logic             w_unused_ghr_msb;

    assign w_full   = (r_count == CNT_W'(QDEPTH));
    assign w_empty  = (r_count == '0);
    assign w_repair = upd_valid && upd_mispredict;

    assign lookup_ready = !w_full && !w_repair;
    assign upd_ready    = !w_full;

    assign w_lookup = lookup_valid && lookup_ready;
    assign w_enq    = upd_valid && upd_ready;
    // Drain whenever the table is not claimed by a lookup this cycle.
    assign w_drain  = !w_empty && (w_full || w_repair || !lookup_valid);

    assign w_idx      = lookup_pc ^ r_ghr;
    assign w_head_idx = r_q_idx[r_head];
    assign w_head_tk  = r_q_tk[r_head];

    assign w_unused_ghr_msb = upd_ghr[IDX_W-1];

    bp_ctr_next u_ctr_next (
        .i_ctr   (r_pht[w_head_idx]),
        .i_taken (w_head_tk),
        .o_ctr   (w_ctr_new)
    );

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_q_idx[r_tail] <= upd_idx;
            r_q_tk[r_tail]  <= upd_taken;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) r_pht[i] <= CTR_RESET;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= w_lookup;
            if (w_lookup) begin
                r_pred_taken <= r_pht[w_idx][1];
                r_pred_idx   <= w_idx;
                r_pred_ghr   <= r_ghr;
            end

            if (w_drain) begin
                r_pht[w_head_idx] <= w_ctr_new;
                r_head            <= r_head + 1'b1;
            end
            if (w_enq) r_tail <= r_tail + 1'b1;

            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_enq && upd_mispredict)
                r_ghr <= {upd_ghr[IDX_W-2:0], upd_taken};
            else if (w_lookup)
                r_ghr <= {r_ghr[IDX_W-2:0], r_pht[w_idx][1]};
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_idx   = r_pred_idx;
    assign pred_ghr   = r_pred_ghr;
    assign ghr        = r_ghr;

endmodule

// File: tb/tb_bp_pht_sched.sv
// Directed and random stimulus for bp_pht_sched against a queue/array model
// of the predictor table, update FIFO and history register.
module tb_bp_pht_sched;

    localparam int IDX_W  = 6;
    localparam int QDEPTH = 2;
    localparam int N      = 1 << IDX_W;
    localparam int MASK   = N - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_pc;
    logic             lookup_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;
    logic             upd_ready;
    logic [IDX_W-1:0] ghr;

    always #5 clock = ~clock;

    bp_pht_sched #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .lookup_ready   (lookup_ready),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .upd_ready      (upd_ready),
        .ghr            (ghr)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: counters as integers 0..3, FIFO entries as idx*2+taken.
    int m_pht [N];
    int m_q [$];
    int m_ghr;
    int e_pv, e_pt, e_pi, e_pg;
    bit last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pht[i] = 1;
        m_q.delete();
        m_ghr = 0;
        e_pv = 0; e_pt = 0; e_pi = 0; e_pg = 0;
    endtask

    task automatic check_outputs();
        chk("pred_valid", 32'(pred_valid), e_pv);
        chk("pred_taken", 32'(pred_taken), e_pt);
        chk("pred_idx",   32'(pred_idx),   e_pi);
        chk("pred_ghr",   32'(pred_ghr),   e_pg);
        chk("ghr",        32'(ghr),        m_ghr);
    endtask

    task automatic step(input bit lv, input int pc, input bit uv, input int uidx,
                        input int ughr, input bit utk, input bit umis);
        bit full, rep, lrdy, urdy, fire, drain;
        int idx, e;
        lookup_valid   = lv;
        lookup_pc      = IDX_W'(pc);
        upd_valid      = uv;
        upd_idx        = IDX_W'(uidx);
        upd_ghr        = IDX_W'(ughr);
        upd_taken      = utk;
        upd_mispredict = umis;
        #1;
        full = (m_q.size() == QDEPTH);
        rep  = uv && umis;
        lrdy = !full && !rep;
        urdy = !full;
        chk("lookup_ready", 32'(lookup_ready), 32'(lrdy));
        chk("upd_ready",    32'(upd_ready),    32'(urdy));
        fire  = lv && lrdy;
        drain = (m_q.size() > 0) && (full || rep || !lv);
        e_pv  = fire;
        if (fire) begin
            idx   = (pc ^ m_ghr) & MASK;
            e_pt  = (m_pht[idx] >= 2) ? 1 : 0;
            e_pi  = idx;
            e_pg  = m_ghr;
            m_ghr = ((m_ghr << 1) | e_pt) & MASK;
        end
        if (drain) begin
            e   = m_q.pop_front();
            idx = e >> 1;
            if (e & 1) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
            else       m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        end
        last_acc = uv && urdy;
        if (last_acc) begin
            m_q.push_back(((uidx & MASK) << 1) | int'(utk));
            if (umis) m_ghr = ((ughr << 1) | int'(utk)) & MASK;
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Present an update, holding it until accepted (bounded).
    task automatic push_upd(input bit lv, input int pc, input int uidx, input bit utk);
        int tries;
        tries = 0;
        do begin
            step(lv, pc, 1, uidx, 0, utk, 0);
            tries++;
        end while (!last_acc && tries < 8);
        chk("upd_accept_bound", 32'(last_acc), 1);
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 0; lookup_pc = '0;
        upd_valid = 0; upd_idx = '0; upd_ghr = '0; upd_taken = 0; upd_mispredict = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        chk("upd_ready_reset", 32'(upd_ready), 1);
        reset = 1'b1;

        // First lookup after reset: idx 5, weak not-taken.
        step(1, 5, 0, 0, 0, 0, 0);

        // Three taken updates to idx 5, then re-predict.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 0, 1, 0);
        idle(2);
        step(1, 5 ^ m_ghr, 0, 0, 0, 0, 0);
        chk("idx5_taken", 32'(pred_taken), 1);

        // Updates under continuous lookup pressure: queue fills, drains one per full cycle.
        for (int i = 0; i < 4; i++) push_upd(1, 20 + i, 1 + i, 1);
        idle(3);

        // Mispredict repair blocks the lookup and rewrites history.
        step(1, 12, 1, 7, 6'b000011, 1, 1);
        chk("repair_ghr", 32'(ghr), 32'b000111);
        step(1, 12, 0, 0, 0, 0, 0);
        chk("repair_idx", 32'(pred_idx), 12 ^ 7);
        idle(3);

        // Saturate idx 0 downward.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0);
        idle(3);
        step(1, m_ghr, 0, 0, 0, 0, 0);
        chk("idx0_nt", 32'(pred_taken), 0);
        chk("idx0_idx", 32'(pred_idx), 0);

        // Reset with two queued not-taken updates and a pending prediction.
        idle(3);
        step(1, 3, 1, 9, 0, 0, 0);
        step(1, 4, 1, 10, 0, 0, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("upd_ready_async", 32'(upd_ready), 1);
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b1;
        // A single taken update moves 01 to 10; a surviving 00 would stay not-taken.
        step(0, 0, 1, 9, 0, 1, 0);
        step(0, 0, 1, 10, 0, 1, 0);
        idle(2);
        step(1, 9 ^ m_ghr, 0, 0, 0, 0, 0);
        chk("post_rst_9", 32'(pred_taken), 1);
        step(1, 10 ^ m_ghr, 0, 0, 0, 0, 0);
        chk("post_rst_10", 32'(pred_taken), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
                 $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, MASK)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
